// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for the RV64M divide/remainder group.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the loop.
module seq_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            div_signed,
  input  logic            divw,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, CORRECT, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [XLEN-1:0] quotient_q, quotient_d;
  logic [XLEN-1:0] remainder_q, remainder_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            divw_q, divw_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;

  logic [XLEN-1:0] op_a, op_b, mag_a, mag_b, min_val;
  logic            sign_a, sign_b, is_dz, is_ovf;
  logic [XLEN+1:0] shl, trial;
  logic [XLEN-1:0] q_res, r_res;

  // Operands reduced to the active width, then split into sign and magnitude
  always_comb begin
    if (divw) begin
      sign_a  = div_signed & dividend[31];
      sign_b  = div_signed & divisor[31];
      op_a    = {{(XLEN-32){sign_a}}, dividend[31:0]};
      op_b    = {{(XLEN-32){sign_b}}, divisor[31:0]};
      min_val = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      sign_a  = div_signed & dividend[XLEN-1];
      sign_b  = div_signed & divisor[XLEN-1];
      op_a    = dividend;
      op_b    = divisor;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    mag_a  = sign_a ? -op_a : op_a;
    mag_b  = sign_b ? -op_b : op_b;
    is_dz  = (op_b == '0);
    is_ovf = div_signed && (op_a == min_val) && (op_b == '1);
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    cnt_d       = cnt_q;
    divw_d      = divw_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    shl         = {rem_q, quo_q[XLEN-1]};
    trial       = shl - {2'b00, dsr_q};
    q_res       = '0;
    r_res       = '0;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_valid) begin
            divw_d    = divw;
            neg_quo_d = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            dsr_d     = mag_b;
            rem_d     = '0;
            dz_d      = is_dz;
            ovf_d     = is_ovf;
            if (is_dz || is_ovf) begin
              // The raw dividend is what both special cases report back
              quo_d   = op_a;
              cnt_d   = '0;
              state_d = CORRECT;
            end else begin
              // Word magnitudes sit in the top half so they shift out first
              quo_d   = divw ? (mag_a << 32) : mag_a;
              cnt_d   = divw ? CW'(32) : CW'(XLEN);
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          if (!trial[XLEN+1]) begin
            rem_d = trial[XLEN:0];
          end else begin
            rem_d = shl[XLEN:0];
          end
          quo_d = {quo_q[XLEN-2:0], ~trial[XLEN+1]};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = CORRECT;
          end
        end
        CORRECT: begin
          if (dz_q) begin
            q_res = '1;
            r_res = quo_q;
          end else if (ovf_q) begin
            q_res = quo_q;
            r_res = '0;
          end else begin
            q_res = neg_quo_q ? -quo_q : quo_q;
            r_res = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
          end
          if (divw_q) begin
            q_res = {{(XLEN-32){q_res[31]}}, q_res[31:0]};
            r_res = {{(XLEN-32){r_res[31]}}, r_res[31:0]};
          end
          quotient_d  = q_res;
          remainder_d = r_res;
          state_d     = DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      cnt_q       <= '0;
      divw_q      <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      cnt_q       <= cnt_d;
      divw_q      <= divw_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign div_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed RV64M cases, random operands
// against an arithmetic reference model, backpressure, flush and reset abort.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_valid;
  logic        div_ready;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        div_signed;
  logic        divw;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] quotient;
  logic [63:0] remainder;

  int total = 0;
  int bad   = 0;

  seq_divider #(.XLEN(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_signed (div_signed),
    .divw       (divw),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // RISC-V division semantics computed directly with language arithmetic
  function automatic void refModel(input logic [63:0] a, input logic [63:0] b,
                                   input logic sgn, input logic w,
                                   output logic [63:0] q, output logic [63:0] r,
                                   output logic special);
    logic [31:0] a32, b32, q32, r32;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      special = 1'b0;
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32; special = 1'b1;
      end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0; special = 1'b1;
      end else if (sgn) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      special = 1'b0;
      if (b == 64'd0) begin
        q = '1; r = a; special = 1'b1;
      end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 64'd0; special = 1'b1;
      end else if (sgn) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic sgn, input logic w);
    dividend   = a;
    divisor    = b;
    div_signed = sgn;
    divw       = w;
    div_valid  = 1'b1;
  endtask

  // Issues one request and checks latency and results; if out_ready is high
  // also checks the single-cycle response and that outputs persist afterwards.
  task automatic runOp(input logic [63:0] a, input logic [63:0] b,
                       input logic sgn, input logic w, input string tag);
    logic [63:0] eq, er;
    logic        special;
    int          cyc;
    int          exp_lat;
    refModel(a, b, sgn, w, eq, er, special);
    exp_lat = special ? 1 : (w ? 33 : 65);
    checkOutput({tag, ".ready_before"}, 64'(div_ready), 64'd1);
    applyStimulus(a, b, sgn, w);
    @(posedge clk); #1;
    div_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
    checkOutput({tag, ".quotient"}, quotient, eq);
    checkOutput({tag, ".remainder"}, remainder, er);
    checkOutput({tag, ".ready_in_done"}, 64'(div_ready), 64'd0);
    if (out_ready) begin
      @(posedge clk); #1;
      checkOutput({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
      checkOutput({tag, ".ready_after"}, 64'(div_ready), 64'd1);
      checkOutput({tag, ".q_hold"}, quotient, eq);
    end
  endtask

  function automatic logic [63:0] pickOperand();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = {$urandom(), $urandom()};
      1: v = 64'($urandom_range(0, 40));
      2: v = '1;
      3: v = 64'h8000_0000_0000_0000;
      4: v = {$urandom(), 32'h8000_0000};
      default: v = {$urandom(), 32'($urandom_range(0, 1000))};
    endcase
    return v;
  endfunction

  function automatic logic [63:0] pickDivisor();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = '1;
      2: v = {$urandom(), 32'hFFFF_FFFF};
      3: v = 64'($urandom_range(1, 20));
      4: v = {32'd0, $urandom()};
      5: v = {$urandom(), 32'd0};
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  initial begin
    logic [63:0] eq, er;
    logic        special;
    logic        seen;
    int          cyc;

    div_valid  = 1'b0;
    dividend   = '0;
    divisor    = '0;
    div_signed = 1'b0;
    divw       = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.div_ready", 64'(div_ready), 64'd1);
    checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset.quotient", quotient, 64'd0);
    checkOutput("reset.remainder", remainder, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed cases");
    runOp(64'd100, 64'd7, 1'b0, 1'b0, "divu_100_7");
    runOp(-64'sd7, 64'd2, 1'b1, 1'b0, "div_m7_2");
    runOp(64'd7, -64'sd2, 1'b1, 1'b0, "div_7_m2");
    runOp(64'h1234_5678_FFFF_FFFF, 64'd1, 1'b0, 1'b1, "divuw_1");
    runOp(64'hDEAD_BEEF_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, "divw_ovf");
    runOp(64'd42, 64'd0, 1'b1, 1'b0, "div_by_zero");
    runOp(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, "div_ovf64");

    $display("[TB] random cases");
    for (int i = 0; i < 30; i++) begin
      runOp(pickOperand(), pickDivisor(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("[TB] backpressure");
    out_ready = 1'b0;
    refModel(-64'sd1000, 64'd33, 1'b1, 1'b0, eq, er, special);
    applyStimulus(-64'sd1000, 64'd33, 1'b1, 1'b0);
    @(posedge clk); #1;
    applyStimulus(64'd5, 64'd1, 1'b0, 1'b0);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("bp.latency", 64'(cyc), 64'd65);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp.valid_hold%0d", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("bp.ready_low%0d", i), 64'(div_ready), 64'd0);
      checkOutput($sformatf("bp.q_stable%0d", i), quotient, eq);
      checkOutput($sformatf("bp.r_stable%0d", i), remainder, er);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp.valid_drop", 64'(out_valid), 64'd0);
    runOp(64'd5, 64'd1, 1'b0, 1'b0, "bp.back_to_back");

    $display("[TB] flush in BUSY");
    applyStimulus(64'd100, 64'd7, 1'b0, 1'b0);
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checkOutput("flush_busy.ready_low", 64'(div_ready), 64'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_busy.ready", 64'(div_ready), 64'd1);
    checkOutput("flush_busy.valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("flush_busy.never_valid", 64'(seen), 64'd0);

    $display("[TB] flush with request in IDLE");
    applyStimulus(64'd9, 64'd3, 1'b0, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    flush = 1'b0;
    checkOutput("flush_idle.ready", 64'(div_ready), 64'd1);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("flush_idle.never_valid", 64'(seen), 64'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(64'd100, 64'd7, 1'b0, 1'b0);
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("rst_mid.busy", 64'(div_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid.quotient", quotient, 64'd0);
    checkOutput("rst_mid.remainder", remainder, 64'd0);
    checkOutput("rst_mid.valid", 64'(out_valid), 64'd0);
    checkOutput("rst_mid.ready", 64'(div_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    runOp(64'd100, 64'd7, 1'b0, 1'b0, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
